// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch queue stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          FETCH_XLEN = 64;

    // Queue entry layout for the default 64-bit PC width; the stage packs {instr, pc} the same way.
    typedef struct packed {
        logic [31:0]           instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

    // Width able to hold 0..depth for queued entries and in-flight credits.
    function automatic int fetch_cred_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Minimum-depth constant shared with users of the queue FIFO in rtl/fetch_fifo.sv.
package fetch_fifo_alias_pkg;
    localparam int FIFO_MIN_DEPTH = 2;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head data is read straight from the storage registers.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0) && !flush;
        // A push into a full queue is only legal when the head leaves in the same cycle.
        do_push  = push && !flush && ((count_q != FULL) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage with a DEPTH-entry queue between a variable-latency in-order imem and decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCSrcD,
    input  logic              JalD,
    input  logic [XLEN-1:0]   PCTargetD,
    input  logic              StallD,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              ValidD,
    output logic [31:0]       InstrD,
    output logic [XLEN-1:0]   PCD,
    output logic [XLEN-1:0]   PCPlus4D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_redirect_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);
    localparam int CW = fetch_cred_w(DEPTH);
    localparam int EW = 32 + XLEN;
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            redirect, req_fire, rsp_ok;
    logic [CW:0]     in_use;
    logic [XLEN-1:0] target_aligned;
    logic            fifo_push, fifo_pop;
    logic [EW-1:0]   fifo_din, fifo_dout;
    logic [CW-1:0]   fifo_count;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    always_comb begin
        redirect       = PCSrcD | JalD;
        target_aligned = PCTargetD & ~XLEN'(3);
        in_use         = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req_valid = !rst && !redirect && (in_use < CAP);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_ok         = imem_rsp_valid && (outstanding_q != '0);

        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
        fifo_push     = 1'b0;
        fifo_din      = {imem_rsp_data, resp_pc_q};
        fifo_pop      = ValidD && !StallD && !redirect;

        if (redirect) begin
            pc_d       = target_aligned;
            resp_pc_d  = target_aligned;
            // Responses already marked for dropping are a subset of outstanding, so every
            // fetch still in flight after this cycle becomes stale exactly once.
            drop_cnt_d = outstanding_q - CW'(rsp_ok);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (rsp_ok) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_comb begin
        ValidD   = (fifo_count != '0);
        InstrD   = ValidD ? fifo_dout[EW-1:XLEN] : NOP_INSTR;
        PCD      = ValidD ? fifo_dout[XLEN-1:0] : '0;
        PCPlus4D = ValidD ? fifo_dout[XLEN-1:0] + XLEN'(4) : '0;
    end

    a_rsp_has_credit: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_q != '0));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirect_q, perf_redirect_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_redirect_d = perf_redirect_q + 32'(redirect);
        perf_bubble_d   = perf_bubble_q + 32'(!ValidD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redirect_q <= '0;
            perf_bubble_q   <= '0;
        end else begin
            perf_redirect_q <= perf_redirect_d;
            perf_bubble_q   <= perf_bubble_d;
        end
    end

    assign perf_redirect_cnt = perf_redirect_q;
    assign perf_bubble_cnt   = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: imem model with per-request latency plus a PC-stream reference model.
`timescale 1ns/1ps
module tb_fetch_queue_stage;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             PCSrcD, JalD, StallD;
    logic [XLEN-1:0]  PCTargetD;
    logic             imem_req_valid, imem_req_ready;
    logic [XLEN-1:0]  imem_req_addr;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rsp_data;
    logic             ValidD;
    logic [31:0]      InstrD;
    logic [XLEN-1:0]  PCD, PCPlus4D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]      perf_redirect_cnt, perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    fetch_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst            (rst),
        .PCSrcD         (PCSrcD),
        .JalD           (JalD),
        .PCTargetD      (PCTargetD),
        .StallD         (StallD),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ValidD         (ValidD),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_bubble_cnt   (perf_bubble_cnt)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        bit          stale;
        int          due;
    } req_t;

    req_t        inflight[$];
    logic [63:0] pop_log[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          queued = 0;
    int          first_valid = -1;
    int          exp_redirects = 0;
    int          exp_bubbles = 0;
    logic [63:0] fetch_pc = '0;
    logic [63:0] exp_pc = '0;
    bit          last_validd, last_reqv;
    int          idx;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F00;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit stall, input bit pcsrc, input bit jal,
                        input logic [63:0] tgt, input bit ready, input int lat);
        bit          redir, rsp, pop, acc, exp_v, exp_rv, stale;
        logic [63:0] acc_addr, tgt_a;
        int          due;
        StallD         = stall;
        PCSrcD         = pcsrc;
        JalD           = jal;
        PCTargetD      = tgt;
        imem_req_ready = ready;
        rsp            = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(inflight[0].addr) : $urandom;
        #1;
        redir = pcsrc | jal;
        exp_v = (queued > 0);
        chk("ValidD", ValidD, exp_v);
        if (exp_v) begin
            chk("PCD", PCD, exp_pc);
            chk("PCPlus4D", PCPlus4D, exp_pc + 64'd4);
            chk("InstrD", InstrD, mem_word(exp_pc));
        end else begin
            chk("InstrD_nop", InstrD, 32'h0000_0013);
            chk("PCD_zero", PCD, 0);
            chk("PCPlus4D_zero", PCPlus4D, 0);
        end
        exp_rv = !redir && ((queued + inflight.size()) < DEPTH);
        chk("imem_req_valid", imem_req_valid, exp_rv);
        if (imem_req_valid) chk("imem_req_addr", imem_req_addr, fetch_pc);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_redirect_cnt", perf_redirect_cnt, 64'(exp_redirects));
        chk("perf_bubble_cnt", perf_bubble_cnt, 64'(exp_bubbles));
`endif
        last_validd = ValidD;
        last_reqv   = imem_req_valid;
        if (ValidD && first_valid < 0) first_valid = cyc;
        pop = exp_v && !stall && !redir;
        if (pop) pop_log.push_back(PCD);
        acc      = imem_req_valid && ready;
        acc_addr = imem_req_addr;
        @(posedge clk);
        stale = 1'b0;
        if (rsp) begin
            stale = inflight[0].stale;
            void'(inflight.pop_front());
        end
        if (redir) begin
            tgt_a    = tgt & ~64'd3;
            queued   = 0;
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            fetch_pc = tgt_a;
            exp_pc   = tgt_a;
            exp_redirects++;
        end else begin
            if (rsp && !stale) queued++;
            if (pop) begin
                queued--;
                exp_pc += 64'd4;
            end
        end
        if (acc) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            inflight.push_back('{acc_addr, 1'b0, due});
            last_due = due;
            if (!redir) fetch_pc += 64'd4;
        end
        if (!exp_v) exp_bubbles++;
        chk("inflight_bound", 64'(inflight.size() <= DEPTH), 1);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit stall, input int lat);
        for (int i = 0; i < n; i++) step(stall, 1'b0, 1'b0, '0, 1'b1, lat);
    endtask

    initial begin
        rst = 1'b1;
        StallD = 1'b0; PCSrcD = 1'b0; JalD = 1'b0; PCTargetD = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ValidD", ValidD, 0);
        chk("rst_InstrD", InstrD, 32'h0000_0013);
        chk("rst_PCD", PCD, 0);
        chk("rst_PCPlus4D", PCPlus4D, 0);
        chk("rst_req_valid", imem_req_valid, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_redirect", perf_redirect_cnt, 0);
        chk("rst_perf_bubble", perf_bubble_cnt, 0);
`endif
        rst = 1'b0;

        run(10, 1'b0, 1);
        chk("first_valid_cycle", 64'(first_valid), 2);
        chk("first_pc0", pop_log[0], 64'h0);
        chk("first_pc1", pop_log[1], 64'h4);
        chk("first_pc2", pop_log[2], 64'h8);

        run(8, 1'b1, 1);
        chk("stall_req_dropped", last_reqv, 0);
        chk("stall_valid_held", last_validd, 1);
        run(4, 1'b0, 1);

        run(3, 1'b0, 3);
        idx = pop_log.size();
        step(1'b0, 1'b0, 1'b1, 64'h20, 1'b1, 1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1);
        chk("jal_valid_after", last_validd, 0);
        run(6, 1'b0, 1);
        chk("jal_pc0", pop_log[idx], 64'h20);
        chk("jal_pc1", pop_log[idx+1], 64'h24);

        idx = pop_log.size();
        step(1'b0, 1'b1, 1'b0, 64'h13, 1'b1, 1);
        run(6, 1'b0, 1);
        chk("br_pc0", pop_log[idx], 64'h10);
        chk("br_pc1", pop_log[idx+1], 64'h14);

        run(3, 1'b1, 1);
        idx = pop_log.size();
        step(1'b1, 1'b0, 1'b1, 64'h100, 1'b1, 1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1);
        chk("stall_redirect_valid", last_validd, 0);
        run(6, 1'b0, 1);
        chk("stall_redirect_pc", pop_log[idx], 64'h100);

        run(4, 1'b0, 5);
        idx = pop_log.size();
        step(1'b0, 1'b0, 1'b1, 64'h200, 1'b1, 5);
        step(1'b0, 1'b1, 1'b0, 64'h300, 1'b1, 1);
        run(14, 1'b0, 1);
        chk("b2b_redirect_pc0", pop_log[idx], 64'h300);
        chk("b2b_redirect_pc1", pop_log[idx+1], 64'h304);

        idx = pop_log.size();
        step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1);
        run(6, 1'b0, 1);
        chk("wrap_pc0", pop_log[idx], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc1", pop_log[idx+1], 64'h0);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step(($urandom_range(0, 9) < 3), (r < 3), (r >= 3 && r < 5),
                 {$urandom, $urandom}, ($urandom_range(0, 3) != 0), $urandom_range(1, 5));
        end
        run(20, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
